// File: rtl/param_divider_if.sv
// Operand/result handshake bundle for param_divider.
// When DIV_SIGNED_EN is defined the bundle also carries the in_signed select.
interface param_divider_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic         in_signed;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  // Producer/consumer side of the divider.
  modport master (
    output in_valid,
    input  in_ready,
    output dividend,
    output divisor,
`ifdef DIV_SIGNED_EN
    output in_signed,
`endif
    input  out_valid,
    output out_ready,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid,
    output in_ready,
    input  dividend,
    input  divisor,
`ifdef DIV_SIGNED_EN
    input  in_signed,
`endif
    output out_valid,
    input  out_ready,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/param_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on
// both sides. A zero divisor skips the iteration and reports div_by_zero.
// Optional signed mode is built only when DIV_SIGNED_EN is defined; the core
// always divides magnitudes and the signs are applied on the way into DONE.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | shifting in one quotient bit per cycle, W cycles total
// DONE  | result held with out_valid high until out_ready
module param_divider #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  param_divider_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  prem_q, prem_d;
  logic [W-1:0]  shf_q, shf_d;
  logic [W-1:0]  dvsr_q, dvsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  remd_q, remd_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    shifted;
  logic          ge;
  logic [W-1:0]  prem_next;
  logic [W-1:0]  quot_next;
  logic [W-1:0]  quot_fix;
  logic [W-1:0]  rem_fix;
  logic [W-1:0]  dvd_mag;
  logic [W-1:0]  dsr_mag;

  // One restoring step. The compare is W+1 bits wide so a divisor with its
  // MSB set is handled; when ge holds the true difference is below the
  // divisor, so its low W bits are exact.
  assign shifted   = {prem_q, shf_q[W-1]};
  assign ge        = (shifted >= {1'b0, dvsr_q});
  assign prem_next = ge ? (shifted[W-1:0] - dvsr_q) : shifted[W-1:0];
  assign quot_next = {shf_q[W-2:0], ge};

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic dvd_neg, dsr_neg;

  assign dvd_neg  = bus.in_signed & bus.dividend[W-1];
  assign dsr_neg  = bus.in_signed & bus.divisor[W-1];
  assign dvd_mag  = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dsr_mag  = dsr_neg ? (~bus.divisor + 1'b1) : bus.divisor;
  // -2^(W-1) / -1 yields magnitude 2^(W-1), which reads back as -2^(W-1).
  assign quot_fix = neg_quot_q ? (~quot_next + 1'b1) : quot_next;
  assign rem_fix  = neg_rem_q ? (~prem_next + 1'b1) : prem_next;

  // Sign flags captured at acceptance, held through CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  // Sign flags load only on a non-zero-divisor acceptance.
  always_comb begin
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (state_q == S_IDLE && bus.in_valid && bus.divisor != '0) begin
      neg_quot_d = dvd_neg ^ dsr_neg;
      neg_rem_d  = dvd_neg;
    end
  end
`else
  assign dvd_mag  = bus.dividend;
  assign dsr_mag  = bus.divisor;
  assign quot_fix = quot_next;
  assign rem_fix  = prem_next;
`endif

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prem_q  <= '0;
      shf_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      shf_q   <= shf_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    shf_d   = shf_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            quot_d  = '1;
            remd_d  = bus.dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            prem_d  = '0;
            shf_d   = dvd_mag;
            dvsr_d  = dsr_mag;
            cnt_d   = CW'(W);
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        prem_d = prem_next;
        shf_d  = quot_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = quot_fix;
          remd_d  = rem_fix;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_param_divider.sv
// Directed bench for param_divider (W=8); signed vectors run only when
// DIV_SIGNED_EN is defined.
module tb_param_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  param_divider_if #(.W(8)) bus ();

  param_divider #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation; elat = edges after the acceptance edge until
  // out_valid is seen. If out_ready is high, also checks the transfer.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edbz, input int elat);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = 8'h00;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, n, elat);
    chk({tag, ".q"}, bus.quotient, eq);
    chk({tag, ".r"}, bus.remainder, er);
    chk({tag, ".dbz"}, bus.div_by_zero, edbz);
    chk({tag, ".in_ready_done"}, bus.in_ready, 0);
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      chk({tag, ".out_valid_after"}, bus.out_valid, 0);
      chk({tag, ".in_ready_after"}, bus.in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
`ifdef DIV_SIGNED_EN
    bus.in_signed = 1'b0;
`endif
    #12;
    chk("rst.in_ready", bus.in_ready, 1);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.q", bus.quotient, 0);
    chk("rst.r", bus.remainder, 0);
    chk("rst.dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op("u200_7",   8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8);
    do_op("u5_0",     8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 0);
    do_op("u255_128", 8'd255, 8'd128, 8'd1,   8'd127, 1'b0, 8);
    do_op("u255_1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8);
    do_op("u0_3",     8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8);
    do_op("u7_200",   8'd7,   8'd200, 8'd0,   8'd7,   1'b0, 8);
    do_op("u255_255", 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8);

    // Back-pressure: hold the result while the inputs are churned.
    bus.out_ready = 1'b0;
    do_op("stall", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.dividend = 8'($urandom);
      bus.divisor  = 8'($urandom);
      @(posedge clk);
      #1;
      chk("stall.q", bus.quotient, 8'd15);
      chk("stall.r", bus.remainder, 8'd2);
      chk("stall.out_valid", bus.out_valid, 1);
      chk("stall.in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.dividend  = 8'd9;
    bus.divisor   = 8'd3;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release.out_valid", bus.out_valid, 0);
    chk("release.in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("release.no_accept", bus.in_ready, 1);
    chk("release.single", bus.out_valid, 0);

    // Reset in the middle of CALC.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", bus.out_valid, 0);
    chk("midrst.in_ready", bus.in_ready, 1);
    chk("midrst.q", bus.quotient, 0);
    chk("midrst.r", bus.remainder, 0);
    chk("midrst.dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op("u100_10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 8);

`ifdef DIV_SIGNED_EN
    bus.in_signed = 1'b1;
    do_op("s-100_7",  8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 8);
    do_op("s100_-7",  8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 8);
    do_op("s-128_-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
    do_op("s-5_0",    8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 0);
    bus.in_signed = 1'b0;
    do_op("u156_7",   8'h9C, 8'h07, 8'd22, 8'd2,  1'b0, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
